acc_ctrl_sequencer: RTL and testbench
=====================================

ACC_CTRL_SEQUENCER -- requirements
Module: acc_ctrl_sequencer

Interface
REQ-001 SHALL have parameter COUNT_W, default 8, width of the completed-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port instr_valid  input  1  upstream offers opcode.
REQ-005 SHALL have port instr_ready  output  1  sequencer accepts opcode this cycle.
REQ-006 SHALL have port opcode  input  3  000 NOP, 001 LDA, 010 LDB, 011 ADD, 100 SUB, 101 OUTA, 110 illegal, 111 HLT.
REQ-007 SHALL have port cf_in, zf_in  input  1 each  carry/zero from the adder stage.
REQ-008 SHALL have ports nLa, nLb  output  1 each  active-low load strobes for A and B registers.
REQ-009 SHALL have ports Ea, Eu, sub, out_sel  output  1 each  A-to-bus enable, ALU-to-bus enable, subtract select, output-mux select (1 = bus).
REQ-010 SHALL have ports cf, zf  output  1 each  registered flags.
REQ-011 SHALL have ports done, illegal  output  1 each  single-cycle completion / illegal-opcode pulses.
REQ-012 SHALL have port halted  output  1  sequencer stopped by HLT.
REQ-013 SHALL have port instr_count  output  COUNT_W  completed instructions, wraps.

Function
REQ-014 SHALL implement states IDLE, T1, T2, DONE, HALT.
REQ-015 IDLE: instr_ready=1; on instr_valid&&instr_ready SHALL latch opcode and go to T1 next cycle; otherwise stay.
REQ-016 instr_ready SHALL be 0 in every state except IDLE; opcode changes outside IDLE SHALL be ignored.
REQ-017 T1 (exactly one cycle) SHALL drive the registered control word for the latched opcode: LDA nLa=0; LDB nLb=0; ADD Eu=1,nLa=0,sub=0; SUB Eu=1,nLa=0,sub=1; OUTA Ea=1,out_sel=1; NOP/illegal/HLT all inactive.
REQ-018 Inactive control word SHALL be nLa=1, nLb=1, Ea=0, Eu=0, sub=0, out_sel=0, and SHALL be driven in every state except T1.
REQ-019 Ea and Eu SHALL never be 1 in the same cycle; nLa and nLb SHALL never be 0 in the same cycle.
REQ-020 T2: for ADD/SUB SHALL sample cf_in/zf_in into cf/zf at the T2->DONE edge; other opcodes SHALL leave cf/zf unchanged.
REQ-021 DONE: done=1 for one cycle, instr_count increments by 1 (all-ones wraps to 0), then IDLE; illegal=1 in the same cycle iff opcode was 110.
REQ-022 Accept-to-next-ready latency SHALL be 4 cycles (accept, T1, T2, DONE) for every opcode except HLT.
REQ-023 HLT SHALL pass T1, T2, DONE (done=1, counted) then enter HALT: halted=1, instr_ready=0, inactive control word, left only by reset.
REQ-024 Back-to-back: instr_valid held high SHALL be accepted on the first IDLE cycle after DONE.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, inactive control word, cf=0, zf=0, done=0, illegal=0, halted=0, instr_count=0.
REQ-026 Reset asserted in T1 SHALL deassert strobes immediately; the interrupted instruction SHALL not count, not update flags, not pulse done.
REQ-027 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Opcode encodings, state enum and the control-word record SHALL live in shared package acc_ctrl_pkg.
REQ-029 Opcode-to-control-word decode SHALL be a combinational sub-module acc_ctrl_decode; state, flags, counter and output registers SHALL stay in acc_ctrl_sequencer.
REQ-030 All outputs SHALL be driven from flops (no combinational path from opcode to control outputs).

Verification
REQ-031 ADD with cf_in=1, zf_in=0: T1 shows Eu=1,nLa=0,sub=0 for exactly one cycle; after DONE cf=1, zf=0, instr_count=1, ready back 4 cycles after accept.
REQ-032 LDA then SUB with zf_in=1 held valid back-to-back: second accept on first IDLE cycle; SUB T1 Eu=1,nLa=0,sub=1; zf=1 after; instr_count=2.
REQ-033 Opcode 110: no strobe active in any cycle, done=1 and illegal=1 together, flags unchanged.
REQ-034 HLT: done pulse, halted=1, instr_ready stays 0 for 20 cycles with instr_valid=1; rst pulse -> IDLE, halted=0, instr_ready=1.
REQ-035 rst asserted mid-T1 of ADD: nLa=1, Eu=0 before next clock edge; instr_count=0, cf/zf=0, no done.
REQ-036 COUNT_W=2, five NOPs: instr_count sequence 1,2,3,0,1; assertion checks REQ-019 across all tests.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared opcode encodings, sequencer states and control-word record for the
// accumulator control sequencer.
package acc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDA  = 3'b001,
    OP_LDB  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_OUTA = 3'b101,
    OP_ILL  = 3'b110,
    OP_HLT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_DONE,
    S_HALT
  } state_e;

  typedef struct packed {
    logic nla;
    logic nlb;
    logic ea;
    logic eu;
    logic sub;
    logic out_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_INACTIVE = '{nla: 1'b1, nlb: 1'b1, ea: 1'b0,
                                           eu: 1'b0, sub: 1'b0, out_sel: 1'b0};

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode-to-control-word decode; NOP, illegal and HLT map to
// the inactive word.
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
(
  input  logic [2:0]  opcode,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = CTRL_INACTIVE;
    case (opcode_e'(opcode))
      OP_LDA:  ctrl.nla = 1'b0;
      OP_LDB:  ctrl.nlb = 1'b0;
      OP_ADD:  begin
        ctrl.eu  = 1'b1;
        ctrl.nla = 1'b0;
      end
      OP_SUB:  begin
        ctrl.eu  = 1'b1;
        ctrl.nla = 1'b0;
        ctrl.sub = 1'b1;
      end
      OP_OUTA: begin
        ctrl.ea      = 1'b1;
        ctrl.out_sel = 1'b1;
      end
      default: ctrl = CTRL_INACTIVE;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_sequencer.sv
// Four-phase instruction sequencer (accept, T1, T2, DONE) with halt state,
// registered flags, completion counter and fully registered outputs.
module acc_ctrl_sequencer
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         opcode,
  input  logic               cf_in,
  input  logic               zf_in,
  output logic               nLa,
  output logic               nLb,
  output logic               Ea,
  output logic               Eu,
  output logic               sub,
  output logic               out_sel,
  output logic               cf,
  output logic               zf,
  output logic               done,
  output logic               illegal,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  state_e     state, state_nxt;
  opcode_e    op_q;
  ctrl_word_t dec_word, ctrl_q;
  logic       accept;

  assign accept = (state == S_IDLE) && instr_valid;

  // Decode sees the incoming opcode so the T1 control word can be
  // registered on the accept edge and appear exactly during T1.
  acc_ctrl_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec_word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_DONE;
      S_DONE:  state_nxt = (op_q == OP_HLT) ? S_HALT : S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      ctrl_q      <= CTRL_INACTIVE;
      instr_ready <= 1'b1;
      cf          <= 1'b0;
      zf          <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      if (accept) op_q <= opcode_e'(opcode);
      ctrl_q      <= accept ? dec_word : CTRL_INACTIVE;
      instr_ready <= (state_nxt == S_IDLE);
      done        <= (state_nxt == S_DONE);
      illegal     <= (state_nxt == S_DONE) && (op_q == OP_ILL);
      halted      <= (state_nxt == S_HALT);
      if (state == S_T2) begin
        instr_count <= instr_count + COUNT_W'(1);
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          cf <= cf_in;
          zf <= zf_in;
        end
      end
    end
  end

  assign nLa     = ctrl_q.nla;
  assign nLb     = ctrl_q.nlb;
  assign Ea      = ctrl_q.ea;
  assign Eu      = ctrl_q.eu;
  assign sub     = ctrl_q.sub;
  assign out_sel = ctrl_q.out_sel;

endmodule

// File: tb/tb_acc_ctrl_sequencer.sv
// Bench for acc_ctrl_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against an instruction-age model.
module tb_acc_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       cf_in = 1'b0;
  logic       zf_in = 1'b0;

  logic       instr_ready, nLa, nLb, Ea, Eu, sub, out_sel, cf, zf, done, illegal, halted;
  logic [7:0] instr_count;
  logic       instr_ready_2, nLa_2, nLb_2, Ea_2, Eu_2, sub_2, out_sel_2, cf_2, zf_2;
  logic       done_2, illegal_2, halted_2;
  logic [1:0] instr_count_2;

  int checks = 0;
  int failures = 0;

  // Model: age of the in-flight instruction (0 = none, 1 = T1, 2 = T2, 3 = DONE)
  int         m_age = 0;
  logic       m_halted = 1'b0;
  logic [2:0] m_op = 3'b000;
  logic       m_cf = 1'b0, m_zf = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic [5:0] exp_w;
  logic       exp_done;
  int         exp5[5];
  int         hc;

  always #5 clk = ~clk;

  acc_ctrl_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .cf_in(cf_in), .zf_in(zf_in), .nLa(nLa), .nLb(nLb),
    .Ea(Ea), .Eu(Eu), .sub(sub), .out_sel(out_sel), .cf(cf), .zf(zf),
    .done(done), .illegal(illegal), .halted(halted), .instr_count(instr_count)
  );

  acc_ctrl_sequencer #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_2),
    .opcode(opcode), .cf_in(cf_in), .zf_in(zf_in), .nLa(nLa_2), .nLb(nLb_2),
    .Ea(Ea_2), .Eu(Eu_2), .sub(sub_2), .out_sel(out_sel_2), .cf(cf_2), .zf(zf_2),
    .done(done_2), .illegal(illegal_2), .halted(halted_2), .instr_count(instr_count_2)
  );

  // {nLa, nLb, Ea, Eu, sub, out_sel} required during T1 for each opcode
  function automatic logic [5:0] t1_word(input logic [2:0] op);
    case (op)
      3'b001:  return 6'b010000;
      3'b010:  return 6'b100000;
      3'b011:  return 6'b010100;
      3'b100:  return 6'b010110;
      3'b101:  return 6'b111001;
      default: return 6'b110000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task model_reset();
    m_age = 0; m_halted = 1'b0; m_op = 3'b000;
    m_cf = 1'b0; m_zf = 1'b0; m_cnt = 8'd0;
  endtask

  task model_step();
    if (m_age == 0) begin
      if (!m_halted && instr_valid) begin
        m_op  = opcode;
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = 3;
      m_cnt = m_cnt + 8'd1;
      if (m_op == 3'b011 || m_op == 3'b100) begin
        m_cf = cf_in;
        m_zf = zf_in;
      end
    end else begin
      m_age = 0;
      if (m_op == 3'b111) m_halted = 1'b1;
    end
  endtask

  task tick(input logic v, input logic [2:0] op, input logic ci, input logic zi);
    instr_valid = v; opcode = op; cf_in = ci; zf_in = zi;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task do_reset();
    instr_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_w    = (m_age == 1) ? t1_word(m_op) : 6'b110000;
      exp_done = (m_age == 3);
      chk("ready", instr_ready, !m_halted && m_age == 0);
      chk("ctrl", {nLa, nLb, Ea, Eu, sub, out_sel}, exp_w);
      chk("done", done, exp_done);
      chk("illegal", illegal, exp_done && m_op == 3'b110);
      chk("halted", halted, m_halted);
      chk("flags", {cf, zf}, {m_cf, m_zf});
      chk("count", instr_count, m_cnt);
      chk("excl", {Ea & Eu, ~nLa & ~nLb}, 2'b00);
      chk("ready2", instr_ready_2, !m_halted && m_age == 0);
      chk("ctrl2", {nLa_2, nLb_2, Ea_2, Eu_2, sub_2, out_sel_2}, exp_w);
      chk("done2", {done_2, illegal_2, halted_2}, {exp_done, exp_done && m_op == 3'b110, m_halted});
      chk("count2", instr_count_2, m_cnt[1:0]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp5[0] = 1; exp5[1] = 2; exp5[2] = 3; exp5[3] = 0; exp5[4] = 1;
    @(negedge clk);
    do_reset();
    chk("rst_ready", instr_ready, 1);
    chk("rst_state", {nLa, nLb, Ea, Eu, done, halted}, 6'b110000);
    chk("rst_count", instr_count, 0);

    // ADD, carry set / zero clear
    tick(1'b1, 3'b011, 1'b1, 1'b0);
    chk("add_t1", {Eu, nLa, sub}, 3'b100);
    tick(1'b0, 3'b000, 1'b1, 1'b0);
    chk("add_t2", {Eu, nLa}, 2'b01);
    tick(1'b0, 3'b000, 1'b1, 1'b0);
    chk("add_done", {done, cf, zf}, 3'b110);
    chk("add_count", instr_count, 1);
    tick(1'b0, 3'b000, 1'b1, 1'b0);
    chk("add_ready", instr_ready, 1);

    // LDA then SUB held valid back-to-back
    do_reset();
    tick(1'b1, 3'b001, 1'b0, 1'b1);
    chk("lda_t1", {nLa, nLb}, 2'b01);
    tick(1'b1, 3'b100, 1'b0, 1'b1);
    tick(1'b1, 3'b100, 1'b0, 1'b1);
    tick(1'b1, 3'b100, 1'b0, 1'b1);
    chk("b2b_ready", instr_ready, 1);
    tick(1'b1, 3'b100, 1'b0, 1'b1);
    chk("sub_t1", {Eu, nLa, sub}, 3'b101);
    tick(1'b0, 3'b000, 1'b0, 1'b1);
    tick(1'b0, 3'b000, 1'b0, 1'b1);
    chk("sub_flags", {cf, zf}, 2'b01);
    chk("sub_count", instr_count, 2);

    // Illegal opcode
    do_reset();
    tick(1'b1, 3'b110, 1'b1, 1'b1);
    tick(1'b0, 3'b000, 1'b1, 1'b1);
    tick(1'b0, 3'b000, 1'b1, 1'b1);
    chk("ill_pulse", {done, illegal, cf, zf}, 4'b1100);

    // HLT
    do_reset();
    tick(1'b1, 3'b111, 1'b0, 1'b0);
    tick(1'b0, 3'b000, 1'b0, 1'b0);
    tick(1'b0, 3'b000, 1'b0, 1'b0);
    chk("hlt_done", done, 1);
    tick(1'b1, 3'b001, 1'b0, 1'b0);
    chk("hlt_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      chk("hlt_ready", instr_ready, 0);
    end
    do_reset();
    chk("hlt_rst", {halted, instr_ready}, 2'b01);

    // Reset in T1 of ADD
    tick(1'b1, 3'b011, 1'b1, 1'b1);
    instr_valid = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1 chk("midrst_strobe", {nLa, Eu}, 2'b10);
    @(negedge clk);
    #1 rst = 1'b0;
    chk("midrst_state", {instr_count, cf, zf, done}, 11'd0);

    // Five NOPs through the 2-bit counter
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 3'b000, 1'b0, 1'b0);
      tick(1'b0, 3'b000, 1'b0, 1'b0);
      tick(1'b0, 3'b000, 1'b0, 1'b0);
      chk("wrap_count", instr_count_2, exp5[i]);
      tick(1'b0, 3'b000, 1'b0, 1'b0);
    end

    // Randomized traffic
    do_reset();
    hc = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] op;
      if (m_halted) begin
        hc++;
        if (hc > 3) begin
          do_reset();
          hc = 0;
        end
      end else if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end
      op = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b011;
      tick(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
